// File: rtl/vid_dbg_pkg.sv
// vid_dbg_pkg: state encoding and default widths shared by the video debug monitors
package vid_dbg_pkg;
   localparam int CNT_WIDTH_DEF = 16;
   localparam int FCNT_WIDTH_DEF = 32;
   localparam logic [1:0] ST_WAIT_SOF = 2'd0;
   localparam logic [1:0] ST_FIRST_LINE = 2'd1;
   localparam logic [1:0] ST_ACTIVE = 2'd2;
   typedef enum logic [1:0] {
      WAIT_SOF = ST_WAIT_SOF,
      FIRST_LINE = ST_FIRST_LINE,
      ACTIVE = ST_ACTIVE
   } meas_state_t;
endpackage

// File: rtl/vid_sat_counter.sv
// vid_sat_counter: loadable up-counter that sticks at all-ones instead of wrapping
module vid_sat_counter
   import vid_dbg_pkg::*;
#(
   parameter int WIDTH = CNT_WIDTH_DEF
) (
   input  logic             aclk,
   input  logic             reset,
   input  logic             inc,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] cnt
);
   always_ff @(posedge aclk)
      if (reset) cnt <= '0;
      else if (load) cnt <= load_val;
      else if (inc && !(&cnt)) cnt <= cnt + 1'b1;
endmodule

// File: rtl/vid_frame_meas.sv
// vid_frame_meas: passive AXI4-Stream video monitor measuring line length, lines per frame and frame count
module vid_frame_meas
   import vid_dbg_pkg::*;
#(
   parameter int CNT_WIDTH = CNT_WIDTH_DEF,
   parameter int FCNT_WIDTH = FCNT_WIDTH_DEF
) (
   input  logic                  aclk,
   input  logic                  reset,
   input  logic                  s_axis_tvalid,
   input  logic                  s_axis_tready,
   input  logic                  s_axis_tuser,
   input  logic                  s_axis_tlast,
   input  logic                  clr_err,
   output logic [CNT_WIDTH-1:0]  pixels_per_line,
   output logic [CNT_WIDTH-1:0]  lines_per_frame,
   output logic [FCNT_WIDTH-1:0] frame_count,
   output logic                  meas_valid,
   output logic                  err_eol_early,
   output logic                  err_eol_late,
   output logic                  err_sof_mid,
   output logic                  err_frame_size
);
   meas_state_t st;
   logic beat, sof, eol, in_frame, first, active, commit;
   logic pix_load, pix_inc, line_load, line_inc;
   logic late_ev, early_ev, sofmid_ev, fsize_ev;
   logic [CNT_WIDTH-1:0] pix_cnt, pix_n, line_cnt, ref_len;
   assign beat = s_axis_tvalid & s_axis_tready;
   assign sof = beat & s_axis_tuser;
   assign eol = beat & s_axis_tlast;
   assign in_frame = st != WAIT_SOF;
   assign first = st == FIRST_LINE;
   assign active = st == ACTIVE;
   assign pix_n = &pix_cnt ? pix_cnt : pix_cnt + 1'b1;
   // SOF+EOL on one beat collapses to a finished 1-pixel first line
   assign pix_load = sof | (eol & in_frame);
   assign pix_inc = beat & in_frame & ~eol;
   assign line_load = sof | (eol & first);
   assign line_inc = eol & active & ~sof;
   assign commit = sof & active;
   assign late_ev = beat & ~sof & ~eol & active & (pix_n >= ref_len);
   assign early_ev = eol & ~sof & active & (pix_n < ref_len);
   assign sofmid_ev = sof & in_frame & (pix_cnt != '0);
   assign fsize_ev = commit & meas_valid & (line_cnt != lines_per_frame);
   vid_sat_counter #(.WIDTH(CNT_WIDTH)) u_pix_cnt (
      .aclk(aclk),
      .reset(reset),
      .inc(pix_inc),
      .load(pix_load),
      .load_val(CNT_WIDTH'(sof & ~eol)),
      .cnt(pix_cnt)
   );
   vid_sat_counter #(.WIDTH(CNT_WIDTH)) u_line_cnt (
      .aclk(aclk),
      .reset(reset),
      .inc(line_inc),
      .load(line_load),
      .load_val(CNT_WIDTH'(eol)),
      .cnt(line_cnt)
   );
   always_ff @(posedge aclk) begin
      if (reset) begin
         st <= WAIT_SOF;
         ref_len <= '0;
         pixels_per_line <= '0;
         lines_per_frame <= '0;
         frame_count <= '0;
         meas_valid <= 1'b0;
         err_eol_early <= 1'b0;
         err_eol_late <= 1'b0;
         err_sof_mid <= 1'b0;
         err_frame_size <= 1'b0;
      end else begin
         st <= sof ? (eol ? ACTIVE : FIRST_LINE) : (eol && first) ? ACTIVE : st;
         ref_len <= (sof && eol) ? CNT_WIDTH'(1) : (eol && first) ? pix_n : ref_len;
         if (commit) begin
            lines_per_frame <= line_cnt;
            pixels_per_line <= ref_len;
            frame_count <= frame_count + 1'b1;
            meas_valid <= 1'b1;
         end
         err_eol_early <= early_ev | (err_eol_early & ~clr_err);
         err_eol_late <= late_ev | (err_eol_late & ~clr_err);
         err_sof_mid <= sofmid_ev | (err_sof_mid & ~clr_err);
         err_frame_size <= fsize_ev | (err_frame_size & ~clr_err);
      end
   end
endmodule

// File: tb/tb_vid_frame_meas.sv
// tb_vid_frame_meas: randomized stream against a line-list model of the monitor, plus pinned scenarios
module tb_vid_frame_meas;
   logic aclk = 1'b0;
   logic reset = 1'b1;
   logic s_axis_tvalid = 1'b0, s_axis_tready = 1'b0, s_axis_tuser = 1'b0, s_axis_tlast = 1'b0;
   logic clr_err = 1'b0;
   logic [15:0] pixels_per_line, lines_per_frame;
   logic [31:0] frame_count;
   logic meas_valid, err_eol_early, err_eol_late, err_sof_mid, err_frame_size;
   int checks = 0, failures = 0;
   bit chk_en = 0, gaps = 0;
   always #5 aclk = ~aclk;
   vid_frame_meas dut (
      .aclk(aclk),
      .reset(reset),
      .s_axis_tvalid(s_axis_tvalid),
      .s_axis_tready(s_axis_tready),
      .s_axis_tuser(s_axis_tuser),
      .s_axis_tlast(s_axis_tlast),
      .clr_err(clr_err),
      .pixels_per_line(pixels_per_line),
      .lines_per_frame(lines_per_frame),
      .frame_count(frame_count),
      .meas_valid(meas_valid),
      .err_eol_early(err_eol_early),
      .err_eol_late(err_eol_late),
      .err_sof_mid(err_sof_mid),
      .err_frame_size(err_frame_size)
   );
   // model: the open frame is a list of completed line lengths plus the pixels seen in the current line
   bit m_synced, m_mv, m_ea, m_la, m_sm, m_fs;
   int m_cur, m_ppl, m_lpf;
   int unsigned m_fc;
   int m_q[$];
   always @(posedge aclk) begin : model
      bit b, s, e, ea, la, sm, fs;
      if (reset) begin
         m_synced = 0; m_mv = 0; m_ea = 0; m_la = 0; m_sm = 0; m_fs = 0;
         m_cur = 0; m_ppl = 0; m_lpf = 0; m_fc = 0;
         m_q.delete();
      end else begin
         b = s_axis_tvalid & s_axis_tready;
         s = b & s_axis_tuser;
         e = b & s_axis_tlast;
         ea = 0; la = 0; sm = 0; fs = 0;
         if (b && (m_synced || s)) begin
            if (s) begin
               if (m_synced && m_cur != 0) sm = 1;
               if (m_synced && m_q.size() > 0) begin
                  if (m_mv && m_q.size() != m_lpf) fs = 1;
                  m_lpf = m_q.size();
                  m_ppl = m_q[0];
                  m_fc++;
                  m_mv = 1;
               end
               m_q.delete();
               m_synced = 1;
               m_cur = 1;
               if (e) begin
                  m_q.push_back(1);
                  m_cur = 0;
               end
            end else begin
               m_cur++;
               if (e) begin
                  if (m_q.size() > 0 && m_cur < m_q[0]) ea = 1;
                  m_q.push_back(m_cur);
                  m_cur = 0;
               end else if (m_q.size() > 0 && m_cur >= m_q[0]) la = 1;
            end
         end
         m_ea = ea | (m_ea & !clr_err);
         m_la = la | (m_la & !clr_err);
         m_sm = sm | (m_sm & !clr_err);
         m_fs = fs | (m_fs & !clr_err);
      end
   end
   task automatic cmp(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask
   always @(negedge aclk) if (chk_en) begin
      cmp("pixels_per_line", pixels_per_line, m_ppl);
      cmp("lines_per_frame", lines_per_frame, m_lpf);
      cmp("frame_count", frame_count, m_fc);
      cmp("meas_valid", meas_valid, m_mv);
      cmp("err_eol_early", err_eol_early, m_ea);
      cmp("err_eol_late", err_eol_late, m_la);
      cmp("err_sof_mid", err_sof_mid, m_sm);
      cmp("err_frame_size", err_frame_size, m_fs);
   end
   task automatic send(input bit u, input bit l, input bit c = 0);
      bit done = 0;
      int tries = 0;
      while (!done) begin
         s_axis_tvalid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
         s_axis_tready = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
         done = s_axis_tvalid & s_axis_tready;
         s_axis_tuser = done ? u : 1'($urandom_range(0, 1));
         s_axis_tlast = done ? l : 1'($urandom_range(0, 1));
         clr_err = c;
         @(posedge aclk); #1;
         if (++tries > 200 && !done) begin
            cmp("send_bound", tries, 200);
            done = 1;
         end
      end
      s_axis_tvalid = 1'b0;
      clr_err = 1'b0;
   endtask
   task automatic line(input int len, input bit sof, input bit clr_last = 0);
      for (int p = 0; p < len; p++) send(sof && p == 0, p == len - 1, clr_last && p == len - 1);
   endtask
   task automatic frame(input int lines, input int len);
      for (int i = 0; i < lines; i++) line(len, i == 0);
   endtask
   task automatic do_reset();
      s_axis_tvalid = 1'b0;
      reset = 1'b1;
      repeat (2) @(posedge aclk);
      #1 reset = 1'b0;
   endtask
   task automatic pulse_clr();
      s_axis_tvalid = 1'b0;
      clr_err = 1'b1;
      @(posedge aclk); #1;
      clr_err = 1'b0;
   endtask
   task automatic expect_meas(input string tag, input int ppl, input int lpf, input int fc, input bit mv);
      cmp({tag, "_ppl"}, pixels_per_line, ppl);
      cmp({tag, "_lpf"}, lines_per_frame, lpf);
      cmp({tag, "_fc"}, frame_count, fc);
      cmp({tag, "_mv"}, meas_valid, mv);
   endtask
   task automatic expect_err(input string tag, input bit ea, input bit la, input bit sm, input bit fs);
      cmp({tag, "_early"}, err_eol_early, ea);
      cmp({tag, "_late"}, err_eol_late, la);
      cmp({tag, "_sofmid"}, err_sof_mid, sm);
      cmp({tag, "_fsize"}, err_frame_size, fs);
   endtask
   task automatic clean_run(input string tag);
      do_reset();
      frame(3, 4);
      line(4, 1);
      expect_meas({tag, "_sof2"}, 4, 3, 1, 1);
      line(4, 0);
      line(4, 0);
      frame(3, 4);
      send(1, 0);
      expect_meas({tag, "_sof4"}, 4, 3, 3, 1);
      expect_err({tag, "_sof4"}, 0, 0, 0, 0);
   endtask
   initial begin
      #900000;
      $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
      $fatal(1, "timeout");
   end
   initial begin
      @(posedge aclk); #1;
      chk_en = 1;
      do_reset();
      expect_meas("reset", 0, 0, 0, 0);
      expect_err("reset", 0, 0, 0, 0);
      clean_run("clean");
      gaps = 1;
      clean_run("gaps");
      gaps = 0;
      do_reset();
      frame(3, 4);
      line(4, 1);
      line(3, 0);
      line(5, 0);
      expect_err("len", 1, 1, 0, 0);
      pulse_clr();
      expect_err("clr", 0, 0, 0, 0);
      line(3, 0, 1);
      expect_err("clr_vs_early", 1, 0, 0, 0);
      pulse_clr();
      do_reset();
      frame(2, 4);
      send(0, 0);
      send(1, 0);
      expect_err("sofmid", 0, 0, 1, 0);
      expect_meas("sofmid", 4, 2, 1, 1);
      send(0, 0);
      send(0, 0);
      send(0, 1);
      line(4, 0);
      line(4, 1);
      expect_meas("resync", 4, 2, 2, 1);
      expect_err("resync", 0, 0, 1, 0);
      do_reset();
      frame(3, 4);
      frame(2, 4);
      line(4, 1);
      expect_meas("fsize", 4, 2, 2, 1);
      cmp("fsize_flag", err_frame_size, 1);
      do_reset();
      line(4, 1);
      send(0, 0);
      do_reset();
      expect_meas("midreset", 0, 0, 0, 0);
      expect_err("midreset", 0, 0, 0, 0);
      send(0, 0);
      send(0, 1);
      send(0, 0);
      expect_meas("ignored", 0, 0, 0, 0);
      frame(2, 3);
      send(1, 1);
      expect_meas("after_reset", 3, 2, 1, 1);
      send(0, 1);
      send(1, 0);
      expect_meas("one_pix", 1, 2, 2, 1);
      do_reset();
      gaps = 1;
      for (int i = 0; i < 600; i++) begin
         if (i == 300) do_reset();
         send($urandom_range(0, 19) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 29) == 0);
      end
      gaps = 0;
      repeat (3) @(posedge aclk);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
